// File: rtl/pin_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pin_ctrl
// Brief    : Two-button PIN enrolment / verification controller with lockout.
// Revision : 1.0 - initial release
// ============================================================================
module pin_ctrl #(
    parameter int DIGITS      = 4,
    parameter int BASE        = 10,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1024,
    localparam int DW = $clog2(BASE),
    localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int FW = $clog2(MAX_TRIES + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          b_esq_i,
    input  logic          b_dir_i,
    input  logic          relock_i,
    input  logic          enroll_req_i,
    output logic          w_o,
    output logic [DW-1:0] digit_o,
    output logic [PW-1:0] pos_o,
    output logic [FW-1:0] fail_cnt_o,
    output logic          enrolled_o,
    output logic          locked_o
);

    localparam int c_TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [1:0] c_ENROLL  = 2'd0;
    localparam logic [1:0] c_VERIFY  = 2'd1;
    localparam logic [1:0] c_GRANTED = 2'd2;
    localparam logic [1:0] c_LOCKED  = 2'd3;

    localparam logic [DW-1:0]   c_TOP_DIGIT = DW'(BASE - 1);
    localparam logic [PW-1:0]   c_LAST_POS  = PW'(DIGITS - 1);
    localparam logic [c_TW-1:0] c_LOCK_LOAD = c_TW'(LOCK_CYCLES - 1);

    logic [1:0]      r_state;
    logic [DW-1:0]   r_digit;
    logic [PW-1:0]   r_pos;
    logic [FW-1:0]   r_fail;
    logic [c_TW-1:0] r_timer;
    logic            r_enrolled;
    logic            r_esq_q;
    logic            r_dir_q;
    logic [DW-1:0]   r_entry [DIGITS];
    logic [DW-1:0]   r_pin   [DIGITS];

    logic [DW-1:0]   w_entry_next [DIGITS];
    logic            w_esq_press;
    logic            w_dir_press;
    logic            w_last;
    logic            w_match;
    logic [FW-1:0]   w_fail_inc;

    // Button copies are refreshed in every state, so a button held across a
    // state change never looks like a fresh press.
    assign w_esq_press = b_esq_i & ~r_esq_q;
    assign w_dir_press = b_dir_i & ~r_dir_q;
    assign w_last      = (r_pos == c_LAST_POS);
    assign w_fail_inc  = r_fail + FW'(1);

    // Entry buffer as it would look with the current digit committed at pos.
    always_comb begin
        w_match = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_entry_next[i] = (r_pos == PW'(i)) ? r_digit : r_entry[i];
            if (w_entry_next[i] != r_pin[i]) begin
                w_match = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= c_ENROLL;
            r_digit    <= '0;
            r_pos      <= '0;
            r_fail     <= '0;
            r_timer    <= '0;
            r_enrolled <= 1'b0;
            r_esq_q    <= 1'b0;
            r_dir_q    <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                r_entry[i] <= '0;
                r_pin[i]   <= '0;
            end
        end else begin
            r_esq_q <= b_esq_i;
            r_dir_q <= b_dir_i;
            case (r_state)
                c_ENROLL, c_VERIFY: begin
                    if (w_esq_press) begin
                        r_digit <= '0;
                        if (!w_last) begin
                            r_pos   <= r_pos + PW'(1);
                            r_entry <= w_entry_next;
                        end else begin
                            r_pos <= '0;
                            for (int i = 0; i < DIGITS; i++) begin
                                r_entry[i] <= '0;
                            end
                            if (r_state == c_ENROLL) begin
                                r_pin      <= w_entry_next;
                                r_enrolled <= 1'b1;
                                r_state    <= c_VERIFY;
                            end else if (w_match) begin
                                r_state <= c_GRANTED;
                                r_fail  <= '0;
                            end else begin
                                r_fail <= w_fail_inc;
                                if (w_fail_inc == FW'(MAX_TRIES)) begin
                                    r_state <= c_LOCKED;
                                    r_timer <= c_LOCK_LOAD;
                                end
                            end
                        end
                    end else if (w_dir_press) begin
                        r_digit <= (r_digit == c_TOP_DIGIT) ? '0 : r_digit + DW'(1);
                    end
                end
                c_GRANTED: begin
                    if (relock_i || enroll_req_i) begin
                        r_state <= relock_i ? c_VERIFY : c_ENROLL;
                        r_digit <= '0;
                        r_pos   <= '0;
                        for (int i = 0; i < DIGITS; i++) begin
                            r_entry[i] <= '0;
                        end
                    end
                end
                default: begin
                    if (r_timer == '0) begin
                        r_state <= c_VERIFY;
                        r_fail  <= '0;
                        r_digit <= '0;
                        r_pos   <= '0;
                        for (int i = 0; i < DIGITS; i++) begin
                            r_entry[i] <= '0;
                        end
                    end else begin
                        r_timer <= r_timer - c_TW'(1);
                    end
                end
            endcase
        end
    end

    assign w_o        = (r_state == c_GRANTED);
    assign locked_o   = (r_state == c_LOCKED);
    assign digit_o    = r_digit;
    assign pos_o      = r_pos;
    assign fail_cnt_o = r_fail;
    assign enrolled_o = r_enrolled;

endmodule
`default_nettype wire

// File: tb/tb_pin_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pin_ctrl
// Brief    : Scoreboard bench for pin_ctrl (default and swept parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pin_ctrl;

    localparam int c_MAXD = 8;
    localparam int c_ENR  = 0;
    localparam int c_VER  = 1;
    localparam int c_GRA  = 2;
    localparam int c_LCK  = 3;

    int p_dig  [2] = '{4, 6};
    int p_base [2] = '{10, 16};
    int p_max  [2] = '{3, 1};
    int p_lock [2] = '{1024, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rn  = 2'b00;
    logic [1:0] esq = 2'b00;
    logic [1:0] dir = 2'b00;
    logic [1:0] rl  = 2'b00;
    logic [1:0] er  = 2'b00;

    logic       w0, en0, lk0, w1, en1, lk1;
    logic [3:0] dg0, dg1;
    logic [1:0] ps0, fc0;
    logic [2:0] ps1;
    logic [0:0] fc1;

    pin_ctrl u_dut0 (
        .clk_i(clk), .rst_n_i(rn[0]), .b_esq_i(esq[0]), .b_dir_i(dir[0]),
        .relock_i(rl[0]), .enroll_req_i(er[0]), .w_o(w0), .digit_o(dg0),
        .pos_o(ps0), .fail_cnt_o(fc0), .enrolled_o(en0), .locked_o(lk0)
    );

    pin_ctrl #(.DIGITS(6), .BASE(16), .MAX_TRIES(1), .LOCK_CYCLES(5)) u_dut1 (
        .clk_i(clk), .rst_n_i(rn[1]), .b_esq_i(esq[1]), .b_dir_i(dir[1]),
        .relock_i(rl[1]), .enroll_req_i(er[1]), .w_o(w1), .digit_o(dg1),
        .pos_o(ps1), .fail_cnt_o(fc1), .enrolled_o(en1), .locked_o(lk1)
    );

    // Reference model: entry is a list of committed digits, lockout is a
    // count of remaining locked cycles.
    int m_st [2], m_dig [2], m_cnt [2], m_fail [2], m_left [2];
    bit m_enr [2], m_pe [2], m_pd [2];
    int m_ent [2][c_MAXD];
    int m_pin [2][c_MAXD];

    typedef struct {
        int n;
        int w, lk, en, dg, ps, fc;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void goto_state(int n, int s);
        m_st[n]  = s;
        m_cnt[n] = 0;
        m_dig[n] = 0;
    endfunction

    function automatic void entry_done(int n);
        bit ok;
        if (m_st[n] == c_ENR) begin
            for (int i = 0; i < p_dig[n]; i++) m_pin[n][i] = m_ent[n][i];
            m_enr[n] = 1'b1;
            goto_state(n, c_VER);
        end else begin
            ok = 1'b1;
            for (int i = 0; i < p_dig[n]; i++)
                if (m_ent[n][i] != m_pin[n][i]) ok = 1'b0;
            if (ok) begin
                goto_state(n, c_GRA);
                m_fail[n] = 0;
            end else begin
                m_fail[n]++;
                if (m_fail[n] == p_max[n]) begin
                    goto_state(n, c_LCK);
                    m_left[n] = p_lock[n];
                end else begin
                    goto_state(n, c_VER);
                end
            end
        end
    endfunction

    function automatic void model_step(int n);
        bit pe, pd;
        if (!rn[n]) begin
            goto_state(n, c_ENR);
            m_fail[n] = 0; m_left[n] = 0; m_enr[n] = 1'b0;
            m_pe[n] = 1'b0; m_pd[n] = 1'b0;
            return;
        end
        pe = esq[n] && !m_pe[n];
        pd = dir[n] && !m_pd[n];
        m_pe[n] = esq[n];
        m_pd[n] = dir[n];
        case (m_st[n])
            c_ENR, c_VER: begin
                if (pe) begin
                    m_ent[n][m_cnt[n]] = m_dig[n];
                    m_cnt[n]++;
                    m_dig[n] = 0;
                    if (m_cnt[n] == p_dig[n]) entry_done(n);
                end else if (pd) begin
                    m_dig[n] = (m_dig[n] + 1) % p_base[n];
                end
            end
            c_GRA: begin
                if (rl[n]) goto_state(n, c_VER);
                else if (er[n]) goto_state(n, c_ENR);
            end
            default: begin
                m_left[n]--;
                if (m_left[n] == 0) begin
                    goto_state(n, c_VER);
                    m_fail[n] = 0;
                end
            end
        endcase
    endfunction

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            exp_t e;
            model_step(n);
            e.n  = n;
            e.w  = int'(m_st[n] == c_GRA);
            e.lk = int'(m_st[n] == c_LCK);
            e.en = int'(m_enr[n]);
            e.dg = m_dig[n];
            e.ps = m_cnt[n];
            e.fc = m_fail[n];
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int aw, alk, aen, adg, aps, afc;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.n == 0) begin
                aw = int'(w0); alk = int'(lk0); aen = int'(en0);
                adg = int'(dg0); aps = int'(ps0); afc = int'(fc0);
            end else begin
                aw = int'(w1); alk = int'(lk1); aen = int'(en1);
                adg = int'(dg1); aps = int'(ps1); afc = int'(fc1);
            end
            n_cmp++;
            if (aw != e.w || alk != e.lk || aen != e.en || adg != e.dg ||
                aps != e.ps || afc != e.fc) begin
                n_bad++;
                $display("FAIL outputs dut%0d t=%0t w/locked/enrolled/digit/pos/fail: got %0d/%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d/%0d",
                         e.n, $time, aw, alk, aen, adg, aps, afc,
                         e.w, e.lk, e.en, e.dg, e.ps, e.fc);
            end
        end
    end

    task automatic tick(int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic tap(int n, bit is_esq);
        if (is_esq) esq[n] = 1'b1;
        else        dir[n] = 1'b1;
        tick(1);
        esq[n] = 1'b0;
        dir[n] = 1'b0;
        tick(1);
    endtask

    // Digits are packed one per hex nibble, first digit most significant.
    task automatic enter(int n, int v);
        for (int i = p_dig[n] - 1; i >= 0; i--) begin
            repeat ((v >> (4 * i)) & 15) tap(n, 1'b0);
            tap(n, 1'b1);
        end
    endtask

    task automatic pulse(int n, bit relock, bit enroll);
        rl[n] = relock;
        er[n] = enroll;
        tick(1);
        rl[n] = 1'b0;
        er[n] = 1'b0;
        tick(1);
    endtask

    task automatic do_reset(int n);
        rn[n] = 1'b0;
        tick(1);
        rn[n] = 1'b1;
        tick(1);
    endtask

    function automatic int rand_pin();
        int v = 0;
        for (int i = 0; i < 4; i++) v = (v << 4) | int'($urandom_range(0, 1));
        return v;
    endfunction

    initial begin
        tick(2);
        rn = 2'b11;
        tick(1);

        // Enrol, verify, relock, PIN change.
        enter(0, 'h1234);
        enter(0, 'h1234);
        pulse(0, 1'b1, 1'b0);
        enter(0, 'h1234);
        pulse(0, 1'b0, 1'b1);
        enter(0, 'h5555);
        enter(0, 'h0000);
        enter(0, 'h5555);
        pulse(0, 1'b1, 1'b1);

        // Digit wrap, then simultaneous esq+dir.
        repeat (11) tap(0, 1'b0);
        esq[0] = 1'b1; dir[0] = 1'b1;
        tick(1);
        esq[0] = 1'b0; dir[0] = 1'b0;
        tick(1);

        // Lockout with presses during the locked window.
        do_reset(0);
        enter(0, 'h0000);
        repeat (3) enter(0, 'h1000);
        repeat (300) tap(0, 1'b0);
        repeat (300) tap(0, 1'b1);
        tick(500);
        enter(0, 'h0000);

        // Held button, then reset after two committed digits.
        pulse(0, 1'b1, 1'b0);
        dir[0] = 1'b1;
        tick(20);
        dir[0] = 1'b0;
        tick(1);
        tap(0, 1'b1);
        tap(0, 1'b1);
        do_reset(0);

        // Swept parameter set.
        enter(1, 'hF0A123);
        enter(1, 'hF0A124);
        tick(10);
        enter(1, 'hF0A123);
        pulse(1, 1'b1, 1'b0);

        // Randomised traffic against a random two-valued PIN.
        enter(0, rand_pin());
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0, 1: enter(0, rand_pin());
                2: pulse(0, 1'b1, 1'b0);
                3: pulse(0, 1'b0, 1'b1);
                default: begin
                    repeat (30) begin
                        esq[0] = ($urandom_range(0, 3) == 0);
                        dir[0] = ($urandom_range(0, 2) == 0);
                        rl[0]  = ($urandom_range(0, 7) == 0);
                        er[0]  = ($urandom_range(0, 7) == 0);
                        tick(1);
                    end
                    esq[0] = 1'b0; dir[0] = 1'b0; rl[0] = 1'b0; er[0] = 1'b0;
                    tick(1);
                end
            endcase
        end

        tick(3);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pin_ctrl.md
# pin_ctrl

Parametrised, clocked PIN enrolment and verification controller for the wallet's two-button front panel. The right button (`b_dir_i`) steps the current digit and the left button (`b_esq_i`) commits it. The first complete entry after reset enrols the PIN; later entries are compared against it. Access is granted on `w_o`, and the block locks out for a fixed time after too many failures. It sits between the debounced button inputs and the signing/unlock logic.

## Interface
Parameters:
- `DIGITS`, 4: PIN length in digits; must be ≥2.
- `BASE`, 10: values per digit (0..BASE-1); must be ≥2.
- `MAX_TRIES`, 3: consecutive failed verifications that trigger lockout; must be ≥1.
- `LOCK_CYCLES`, 1024: lockout duration in clock cycles; must be ≥1.
- Derived widths: `DW = $clog2(BASE)`; `PW = max(1,$clog2(DIGITS))`; `FW = $clog2(MAX_TRIES+1)`.

Ports:
- `clk_i` input 1: single clock.
- `rst_n_i` input 1: reset, synchronous, active-low.
- `b_esq_i` input 1: commit button; debounced level, synchronous to `clk_i`.
- `b_dir_i` input 1: increment button; debounced level, synchronous to `clk_i`.
- `relock_i` input 1: single-cycle pulse; leaves GRANTED.
- `enroll_req_i` input 1: single-cycle pulse; when in GRANTED, starts a PIN change.
- `w_o` output 1: access granted; high only in GRANTED.
- `digit_o` output DW: digit value currently being edited.
- `pos_o` output PW: index of the digit being edited (0 = first).
- `fail_cnt_o` output FW: consecutive failed verifications.
- `enrolled_o` output 1: a PIN is stored.
- `locked_o` output 1: block is in LOCKED.

## Operation
- **Press detection.** A press is a rising edge of a button: the input is high this cycle and its registered copy is low. Holding a button produces one press. Registered copies reset to 0.
- **Entry behaviour** (ENROLL and VERIFY only):
  - `dir` press: `digit ← (digit==BASE-1) ? 0 : digit+1`.
  - `esq` press: write `digit` into entry slot `pos`, then `digit←0` and `pos←pos+1`.
  - `esq` press at `pos==DIGITS-1`: the entry is complete and `pos←0`.
  - Both presses in the same cycle: `esq` wins. The pre-increment digit is committed and the `dir` press is dropped.
- **States:**
  - **ENROLL** (reset state):
    - On complete entry, the stored PIN is loaded from the entry buffer, `enrolled_o←1`, and the state goes to VERIFY.
    - When entered from GRANTED, the old PIN stays stored and active until the new entry completes.
  - **VERIFY:**
    - On complete entry, all DIGITS slots are compared, with the final digit taken from the current `digit`.
    - Match: go to GRANTED and set `fail_cnt←0`.
    - Mismatch: `fail_cnt←fail_cnt+1`. If the new value equals MAX_TRIES, go to LOCKED and load the timer with LOCK_CYCLES-1; otherwise stay in VERIFY.
  - **GRANTED:**
    - `w_o=1`; button presses are ignored.
    - `relock_i` → VERIFY.
    - `enroll_req_i` → ENROLL.
    - Both asserted in the same cycle: `relock_i` wins.
  - **LOCKED:**
    - `locked_o=1`; button presses are ignored; the timer decrements every cycle.
    - When the timer is 0: go to VERIFY and set `fail_cnt←0`.
- **On every state change,** `digit` and `pos` are cleared to 0 and the entry buffer is cleared.
- **Security rules:** the stored PIN never appears on any output, and no partial-match information is exposed.

## Timing
- Reset (`rst_n_i` low at a rising edge) puts the block in ENROLL with:
  - all outputs 0 (`w_o`, `digit_o`, `pos_o`, `fail_cnt_o`, `enrolled_o`, `locked_o`);
  - stored PIN, entry buffer, timer and button registers all 0.
- Reset mid-entry or in any other state has the same effect: the stored PIN is lost.
- A press sampled at edge k is reflected on `digit_o`/`pos_o` immediately after edge k.
- Final `esq` sampled at edge k: `w_o`, `enrolled_o`, `fail_cnt_o` and `locked_o` all update immediately after edge k.
- `relock_i` sampled at edge k: `w_o` is 0 after edge k.
- LOCKED lasts exactly LOCK_CYCLES cycles. `locked_o` is high for LOCK_CYCLES cycles, then the block is in VERIFY.
- A button still held across a state change does not generate a new press. It must be released and pressed again.

## Test plan
- **Enrol then verify OK** (defaults): enrol 1-2-3-4 (1/2/3/4 `dir` presses before each `esq`), then enter 1-2-3-4 → `enrolled_o=1` after the 4th enrol `esq`; `w_o=1` the cycle after the 8th `esq`; `fail_cnt_o=0`.
- **Digit wrap and simultaneous presses:** 11 `dir` presses → `digit_o=1`. Then `esq` and `dir` asserted together at `digit_o=1` → slot gets 1, `pos_o` advances, `digit_o=0`.
- **Lockout:** enrol 0-0-0-0, enter 1-0-0-0 three times → `fail_cnt_o` goes 1, 2, 3. `locked_o=1` for exactly 1024 cycles; presses during lockout have no effect. Afterwards state is VERIFY with `fail_cnt_o=0`, and entering 0-0-0-0 gives `w_o=1`.
- **Relock and PIN change:**
  - In GRANTED, pulse `relock_i` → `w_o=0`.
  - Re-verify, pulse `enroll_req_i`, enrol 5-5-5-5; entering 0-0-0-0 fails and 5-5-5-5 passes.
  - `relock_i` and `enroll_req_i` in the same cycle → VERIFY.
- **Held button and reset mid-entry:** holding `dir` for 20 cycles → `digit_o=1`. Reset after 2 committed digits → all outputs 0, `enrolled_o=0`, state ENROLL.
- **Parameter sweep:** `DIGITS=6`, `BASE=16`, `MAX_TRIES=1`, `LOCK_CYCLES=5`: enrol F-0-A-1-2-3; one wrong entry → `locked_o` high for 5 cycles.
